// File: rtl/gcd_datapath.sv
// Operand registers and compare logic for the subtractive GCD engine.
// Applies the controller's command each clock and rejects any command that is illegal in the current state.
module gcd_datapath #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [1:0]       ctrl,
    output logic [1:0]       status,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             busy,
    output logic [WIDTH-1:0] iter_count,
    output logic             err
);

    localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] MAX_C  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

    localparam logic [1:0] ST_DONE = 2'd0;
    localparam logic [1:0] ST_AGT  = 2'd1;
    localparam logic [1:0] ST_ALT  = 2'd2;

    localparam logic [1:0] CMD_HOLD   = 2'd0;
    localparam logic [1:0] CMD_SUB_A  = 2'd1;
    localparam logic [1:0] CMD_SUB_B  = 2'd2;
    localparam logic [1:0] CMD_FINISH = 2'd3;

    logic [WIDTH-1:0] a_r, b_r, result_r, iter_r;
    logic             valid_r, busy_r, err_r;

    logic [WIDTH-1:0] a_s, b_s, result_s, iter_s, iter_inc_s;
    logic             valid_s, busy_s, err_s;
    logic [1:0]       status_s;

    assign iter_inc_s = (iter_r == MAX_C) ? iter_r : (iter_r + ONE_C);

    // Compare status straight off the operand registers; a zero operand counts as done.
    always_comb begin
        status_s = ST_DONE;
        if ((a_r == ZERO_C) || (b_r == ZERO_C) || (a_r == b_r)) begin
            status_s = ST_DONE;
        end else if (a_r > b_r) begin
            status_s = ST_AGT;
        end else begin
            status_s = ST_ALT;
        end
    end

    // Next-state logic: load wins, then idle rejection, then a command checked against status.
    always_comb begin
        a_s      = a_r;
        b_s      = b_r;
        result_s = result_r;
        valid_s  = valid_r;
        busy_s   = busy_r;
        iter_s   = iter_r;
        err_s    = err_r;
        if (load) begin
            a_s     = a_in;
            b_s     = b_in;
            busy_s  = 1'b1;
            valid_s = 1'b0;
            iter_s  = ZERO_C;
            err_s   = 1'b0;
        end else if (ctrl == CMD_HOLD) begin
            err_s = err_r;
        end else if (!busy_r && !valid_r) begin
            err_s = 1'b1;
        end else begin
            case (ctrl)
                CMD_SUB_A: begin
                    if (status_s == ST_AGT) begin
                        a_s    = a_r - b_r;
                        iter_s = iter_inc_s;
                    end else begin
                        err_s = 1'b1;
                    end
                end
                CMD_SUB_B: begin
                    if (status_s == ST_ALT) begin
                        b_s    = b_r - a_r;
                        iter_s = iter_inc_s;
                    end else begin
                        err_s = 1'b1;
                    end
                end
                CMD_FINISH: begin
                    if (status_s == ST_DONE) begin
                        result_s = (a_r == ZERO_C) ? b_r : a_r;
                        valid_s  = 1'b1;
                        busy_s   = 1'b0;
                    end else begin
                        err_s = 1'b1;
                    end
                end
                default: begin
                    err_s = err_r;
                end
            endcase
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_r      <= ZERO_C;
            b_r      <= ZERO_C;
            result_r <= ZERO_C;
            valid_r  <= 1'b0;
            busy_r   <= 1'b0;
            iter_r   <= ZERO_C;
            err_r    <= 1'b0;
        end else begin
            a_r      <= a_s;
            b_r      <= b_s;
            result_r <= result_s;
            valid_r  <= valid_s;
            busy_r   <= busy_s;
            iter_r   <= iter_s;
            err_r    <= err_s;
        end
    end

    assign status       = status_s;
    assign result       = result_r;
    assign result_valid = valid_r;
    assign busy         = busy_r;
    assign iter_count   = iter_r;
    assign err          = err_r;

endmodule

// File: tb/tb_gcd_datapath.sv
// Bench for gcd_datapath: a behavioural model compared every cycle, plus
// hand-computed pinned expectations for the directed GCD scenarios.
module tb_gcd_datapath;

    localparam int WIDTH = 8;
    localparam int MAXV  = (1 << WIDTH) - 1;

    logic             clk;
    logic             reset;
    logic             load;
    logic [WIDTH-1:0] a_in, b_in;
    logic [1:0]       ctrl;
    logic [1:0]       status;
    logic [WIDTH-1:0] result;
    logic             result_valid;
    logic             busy;
    logic [WIDTH-1:0] iter_count;
    logic             err;

    gcd_datapath #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .load(load), .a_in(a_in), .b_in(b_in),
        .ctrl(ctrl), .status(status), .result(result), .result_valid(result_valid),
        .busy(busy), .iter_count(iter_count), .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model state (written only by the stimulus process)
    int ma, mb, mres, mvalid, mbusy, miter, merr;

    // Pinned literal expectations for the next falling edge
    int    pin_sel [8];
    int    pin_exp [8];
    string pin_nm  [8];
    int    pin_cnt = 0;

    // Counters (written only by the compare process)
    int n_run  = 0;
    int n_fail = 0;

    function automatic int exp_status(input int a, input int b);
        if (a == 0 || b == 0 || a == b) return 0;
        if (a > b) return 1;
        return 2;
    endfunction

    function automatic int dut_field(input int sel);
        case (sel)
            0: return int'(status);
            1: return int'(result);
            2: return int'(result_valid);
            3: return int'(busy);
            4: return int'(iter_count);
            5: return int'(err);
            default: return -1;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Compare process: every falling edge, DUT against the model, then any pinned literals.
    always @(negedge clk) begin
        chk("model_status",       int'(status),       exp_status(ma, mb));
        chk("model_result",       int'(result),       mres);
        chk("model_result_valid", int'(result_valid), mvalid);
        chk("model_busy",         int'(busy),         mbusy);
        chk("model_iter_count",   int'(iter_count),   miter);
        chk("model_err",          int'(err),          merr);
        for (int i = 0; i < pin_cnt; i++)
            chk(pin_nm[i], dut_field(pin_sel[i]), pin_exp[i]);
    end

    task automatic model_reset();
        ma = 0; mb = 0; mres = 0; mvalid = 0; mbusy = 0; miter = 0; merr = 0;
    endtask

    task automatic model_edge(input bit l, input int a, input int b, input int c);
        int st;
        st = exp_status(ma, mb);
        if (l) begin
            ma = a; mb = b; mbusy = 1; mvalid = 0; miter = 0; merr = 0;
        end else if (c == 0) begin
            merr = merr;
        end else if (mbusy == 0 && mvalid == 0) begin
            merr = 1;
        end else if (c == 1 && st == 1) begin
            ma = ma - mb; miter = (miter < MAXV) ? miter + 1 : MAXV;
        end else if (c == 2 && st == 2) begin
            mb = mb - ma; miter = (miter < MAXV) ? miter + 1 : MAXV;
        end else if (c == 3 && st == 0) begin
            mres = (ma == 0) ? mb : ma; mvalid = 1; mbusy = 0;
        end else begin
            merr = 1;
        end
    endtask

    task automatic pin(input string name, input int sel, input int exp);
        pin_nm[pin_cnt]  = name;
        pin_sel[pin_cnt] = sel;
        pin_exp[pin_cnt] = exp;
        pin_cnt++;
    endtask

    task automatic step(input bit l, input int a, input int b, input int c);
        @(negedge clk);
        #1;
        pin_cnt = 0;
        load = l;
        a_in = a[WIDTH-1:0];
        b_in = b[WIDTH-1:0];
        ctrl = c[1:0];
        @(posedge clk);
        model_edge(l, a, b, c);
        #1;
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; a_in = '0; b_in = '0; ctrl = 2'd0;
        model_reset();
        #1 reset = 1'b0;
        pin("rst_status", 0, 0); pin("rst_valid", 2, 0);
        pin("rst_busy", 3, 0);   pin("rst_err", 5, 0);
        @(negedge clk);
        #1 pin_cnt = 0;
        #1 reset = 1'b1;

        // 12, 8 -> 4 in two subtractions
        step(1, 12, 8, 0); pin("t1_status_load", 0, 1);
        step(0, 0, 0, 1);  pin("t1_status_a4", 0, 2);
        step(0, 0, 0, 2);  pin("t1_status_b4", 0, 0);
        step(0, 0, 0, 3);
        pin("t1_result", 1, 4); pin("t1_valid", 2, 1); pin("t1_busy", 3, 0);
        pin("t1_iter", 4, 2);   pin("t1_err", 5, 0);

        // zero operand finishes immediately
        step(1, 0, 9, 0);  pin("t2_status", 0, 0); pin("t2_busy", 3, 1);
        step(0, 0, 0, 3);  pin("t2_result", 1, 9); pin("t2_iter", 4, 0);

        // 255, 1 -> 254 subtractions
        step(1, 255, 1, 0); pin("t3_status_load", 0, 1);
        for (int i = 0; i < 254; i++) step(0, 0, 0, 1);
        pin("t3_status_end", 0, 0); pin("t3_iter", 4, 254);
        step(0, 0, 0, 3);  pin("t3_result", 1, 1); pin("t3_valid", 2, 1);
        step(0, 0, 0, 3);  pin("t3_relatch_result", 1, 1); pin("t3_relatch_err", 5, 0);
        step(0, 0, 0, 1);  pin("t3_sub_after_done_err", 5, 1);

        // illegal subtract, cleared by the next load
        step(1, 5, 9, 0);  pin("t4_status", 0, 2);
        step(0, 0, 0, 1);  pin("t4_err", 5, 1); pin("t4_status_hold", 0, 2);
        step(1, 1, 1, 0);  pin("t4_err_cleared", 5, 0);

        // reload mid-computation
        step(1, 30, 18, 0);
        step(0, 0, 0, 1);  pin("t5_status_a12", 0, 2);
        step(0, 0, 0, 2);  pin("t5_status_b6", 0, 1); pin("t5_iter", 4, 2);
        step(1, 7, 7, 0);
        pin("t5_iter_reload", 4, 0); pin("t5_busy", 3, 1);
        pin("t5_valid", 2, 0);       pin("t5_status", 0, 0);
        step(0, 0, 0, 3);  pin("t5_result", 1, 7);

        // asynchronous reset between edges
        step(1, 40, 15, 0);
        step(0, 0, 0, 1);  pin("t6_iter_pre", 4, 1);
        #2;
        load = 1'b0; ctrl = 2'd0;
        reset = 1'b0;
        model_reset();
        pin_cnt = 0;
        pin("t6_rst_result", 1, 0); pin("t6_rst_busy", 3, 0);
        pin("t6_rst_iter", 4, 0);   pin("t6_rst_status", 0, 0);
        @(negedge clk);
        #1 pin_cnt = 0;
        #1 reset = 1'b1;
        step(0, 0, 0, 1);  pin("t6_idle_err", 5, 1); pin("t6_idle_busy", 3, 0);

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
